// File: rtl/pipe_scoreboard_if.sv
// rtl/pipe_scoreboard_if.sv - decode-to-scoreboard issue bundle and hazard/forwarding results
interface pipe_scoreboard_if #(
    parameter int NREG  = 16,
    parameter int DEPTH = 3,
    parameter int NRP   = 3
);
    localparam int AW = $clog2(NREG);
    localparam int SW = $clog2(DEPTH + 1);

    logic                issue_valid;
    logic                issue_wr;
    logic [AW-1:0]       issue_rd;
    logic                issue_load;
    logic [NRP*AW-1:0]   issue_rs;
    logic [NRP-1:0]      issue_rs_en;
    logic                flush;
    logic                stall;
    logic [NRP*SW-1:0]   fwd_sel;
    logic [31:0]         stall_cnt;

    modport master (
        output issue_valid, issue_wr, issue_rd, issue_load, issue_rs, issue_rs_en, flush,
        input  stall, fwd_sel, stall_cnt
    );

    modport slave (
        input  issue_valid, issue_wr, issue_rd, issue_load, issue_rs, issue_rs_en, flush,
        output stall, fwd_sel, stall_cnt
    );
endinterface

// File: rtl/pipe_scoreboard.sv
// rtl/pipe_scoreboard.sv - shift-register scoreboard issuing stall and registered forwarding selects
module pipe_scoreboard #(
    parameter int NREG        = 16,
    parameter int DEPTH       = 3,
    parameter int NRP         = 3,
    parameter int LOAD_READY  = 3,
    parameter int ZERO_REG_EN = 0
) (
    input logic              clk,
    input logic              reset,
    pipe_scoreboard_if.slave bus
);
    localparam int AW = $clog2(NREG);
    localparam int SW = $clog2(DEPTH + 1);

    logic            r_vld [1:DEPTH];
    logic            r_wr  [1:DEPTH];
    logic [AW-1:0]   r_rd  [1:DEPTH];
    logic            r_ld  [1:DEPTH];
    logic [NRP*SW-1:0] r_fwd;
    logic [31:0]     r_cnt;

    logic [NRP-1:0]    w_hazard;
    logic [NRP*SW-1:0] w_fwd_nxt;
    logic              w_stall;
    logic              w_issue;

    always_comb begin
        logic [AW-1:0] rs;
        logic          hit;
        int            slot;
        int            rdy;
        w_hazard  = '0;
        w_fwd_nxt = '0;
        for (int p = 0; p < NRP; p++) begin
            rs   = bus.issue_rs[p*AW +: AW];
            hit  = 1'b0;
            slot = 0;
            rdy  = 2;
            // Scan oldest to youngest so the youngest matching producer wins.
            for (int k = DEPTH; k >= 1; k--) begin
                if (r_vld[k] && r_wr[k] && (r_rd[k] == rs)) begin
                    hit  = 1'b1;
                    slot = k;
                    rdy  = r_ld[k] ? LOAD_READY : 2;
                end
            end
            if (!bus.issue_rs_en[p] || ((ZERO_REG_EN != 0) && (rs == '0)))
                hit = 1'b0;
            if (hit) begin
                if (slot + 1 < rdy)
                    w_hazard[p] = 1'b1;
                // A producer in the last slot is written before decode reads the file.
                if (slot < DEPTH)
                    w_fwd_nxt[p*SW +: SW] = SW'(slot + 1);
            end
        end
    end

    assign w_stall = bus.issue_valid && !bus.flush && (|w_hazard);
    assign w_issue = bus.issue_valid && !bus.flush && !w_stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 1; k <= DEPTH; k++) begin
                r_vld[k] <= 1'b0;
                r_wr[k]  <= 1'b0;
                r_rd[k]  <= '0;
                r_ld[k]  <= 1'b0;
            end
            r_fwd <= '0;
            r_cnt <= '0;
        end else begin
            for (int k = DEPTH; k >= 2; k--) begin
                r_vld[k] <= r_vld[k-1];
                r_wr[k]  <= r_wr[k-1];
                r_rd[k]  <= r_rd[k-1];
                r_ld[k]  <= r_ld[k-1];
            end
            r_vld[1] <= w_issue;
            r_wr[1]  <= w_issue && bus.issue_wr;
            r_rd[1]  <= w_issue ? bus.issue_rd : '0;
            r_ld[1]  <= w_issue && bus.issue_load;
            r_fwd    <= w_issue ? w_fwd_nxt : '0;
            if (w_stall && (r_cnt != 32'hFFFF_FFFF))
                r_cnt <= r_cnt + 32'd1;
        end
    end

    assign bus.stall     = w_stall;
    assign bus.fwd_sel   = r_fwd;
    assign bus.stall_cnt = r_cnt;
endmodule
